// File: rtl/store_trace_pkg.sv
// Shared types and defaults for the store trace monitor.
// Status encodings, signature constants and the 64-bit trace entry layout.
package store_trace_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_PASS    = 2'b01,
    ST_FAIL    = 2'b10,
    ST_TIMEOUT = 2'b11
  } status_e;

  localparam logic [31:0] SIG_ADDR_DEF = 32'd100;
  localparam logic [31:0] SIG_DATA_DEF = 32'd25;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO of trace entries with an exact occupancy count.
// The head reads as zero while empty so consumers never see stale entries.
module trace_fifo
  import store_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  trace_entry_t wdata_i,
  output trace_entry_t rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  level_o
);

  trace_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   lvl_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (lvl_q == '0);
  assign full_o  = (lvl_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   lvl_q <= lvl_q + 1'b1;
        2'b01:   lvl_q <= lvl_q - 1'b1;
        default: lvl_q <= lvl_q;
      endcase
    end
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_q];
  assign level_o = lvl_q;

endmodule

// File: rtl/store_trace_monitor.sv
// Observes core data-memory stores, traces them into a FIFO and decides the
// run outcome (PASS / FAIL / TIMEOUT) with a registered halt request.
module store_trace_monitor
  import store_trace_pkg::*;
#(
  parameter int          DEPTH          = 8,
  parameter logic [31:0] SIG_ADDR       = SIG_ADDR_DEF,
  parameter logic [31:0] SIG_DATA       = SIG_DATA_DEF,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd2000,
  parameter int          CNT_W          = 16,
  parameter int          LW             = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_write,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      write_data,
  output logic             t_valid,
  output logic [31:0]      t_addr,
  output logic [31:0]      t_data,
  input  logic             t_ready,
  output logic [LW-1:0]    fifo_level,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] store_count,
  output logic [1:0]       status,
  output logic             halt_req
);

  status_e          status_q;
  logic             halt_q;
  logic [15:0]      cyc_q;
  logic [CNT_W-1:0] store_cnt_q;
  logic [CNT_W-1:0] drop_cnt_q;
  logic             ovf_q;

  logic             store_ev;
  logic             pop;
  logic             push;
  logic             drop;
  logic             full;
  logic             empty;
  trace_entry_t     wr_entry;
  trace_entry_t     head;

  assign store_ev = mem_write & (status_q == ST_RUN);
  assign pop      = ~empty & t_ready;
  assign drop     = store_ev & full & ~pop;
  assign push     = store_ev & ~drop;
  assign wr_entry = '{addr: alu_result, data: write_data};

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );

  // State | meaning
  // RUN     | observing stores, cycle counter running
  // PASS    | signature store carried the expected value
  // FAIL    | signature store carried any other value
  // TIMEOUT | no signature store within TIMEOUT_CYCLES
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q <= ST_RUN;
      halt_q   <= 1'b0;
      cyc_q    <= '0;
    end else begin
      halt_q <= halt_q | (status_q != ST_RUN);
      if (status_q == ST_RUN) begin
        // A signature store on the timeout cycle still decides the outcome.
        if (store_ev && (alu_result == SIG_ADDR)) begin
          status_q <= (write_data == SIG_DATA) ? ST_PASS : ST_FAIL;
        end else if (cyc_q == TIMEOUT_CYCLES - 16'd1) begin
          status_q <= ST_TIMEOUT;
        end else begin
          cyc_q <= cyc_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      store_cnt_q <= '0;
      drop_cnt_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      if (store_ev && !(&store_cnt_q)) store_cnt_q <= store_cnt_q + 1'b1;
      if (drop) begin
        ovf_q <= 1'b1;
        if (!(&drop_cnt_q)) drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  assign t_valid     = ~empty;
  assign t_addr      = head.addr;
  assign t_data      = head.data;
  assign overflow    = ovf_q;
  assign drop_count  = drop_cnt_q;
  assign store_count = store_cnt_q;
  assign status      = status_q;
  assign halt_req    = halt_q;

endmodule

// File: tb/tb_store_trace_monitor.sv
// Directed bench for store_trace_monitor: queue-based reference model compared
// every cycle, plus literal expectations taken from the scenario walkthroughs.
module tb_store_trace_monitor;

  localparam int          DEPTH = 8;
  localparam int          TO    = 40;
  localparam int          CNT_W = 4;
  localparam int          LW    = $clog2(DEPTH) + 1;
  localparam int          SMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             mem_write;
  logic [31:0]      alu_result;
  logic [31:0]      write_data;
  logic             t_valid;
  logic [31:0]      t_addr;
  logic [31:0]      t_data;
  logic             t_ready;
  logic [LW-1:0]    fifo_level;
  logic             overflow;
  logic [CNT_W-1:0] drop_count;
  logic [CNT_W-1:0] store_count;
  logic [1:0]       status;
  logic             halt_req;

  int n_checks = 0;
  int n_fail   = 0;

  store_trace_monitor #(
    .DEPTH(DEPTH), .SIG_ADDR(32'd100), .SIG_DATA(32'd25),
    .TIMEOUT_CYCLES(16'(TO)), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .mem_write(mem_write), .alu_result(alu_result),
    .write_data(write_data), .t_valid(t_valid), .t_addr(t_addr), .t_data(t_data),
    .t_ready(t_ready), .fifo_level(fifo_level), .overflow(overflow),
    .drop_count(drop_count), .store_count(store_count), .status(status),
    .halt_req(halt_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outcome status 0..3, trace as a queue, plain integer counters.
  logic [63:0] m_q[$];
  int          m_status;
  bit          m_halt;
  int          m_runs;
  int          m_sc;
  int          m_dc;
  bit          m_ovf;
  logic [63:0] popped[$];

  task automatic model_clear();
    m_q.delete();
    m_status = 0;
    m_halt   = 0;
    m_runs   = 0;
    m_sc     = 0;
    m_dc     = 0;
    m_ovf    = 0;
  endtask

  always @(negedge rst) model_clear();

  always @(posedge clk) begin
    int  prev;
    bit  st;
    if (rst) begin
      prev = m_status;
      st   = mem_write && (m_status == 0);
      if (m_q.size() > 0 && t_ready) m_q.delete(0);
      if (st) begin
        if (m_sc < SMAX) m_sc++;
        if (m_q.size() < DEPTH) m_q.push_back({alu_result, write_data});
        else begin
          m_ovf = 1;
          if (m_dc < SMAX) m_dc++;
        end
      end
      if (prev == 0) begin
        m_runs++;
        if (st && alu_result == 32'd100) m_status = (write_data == 32'd25) ? 1 : 2;
        else if (m_runs == TO) m_status = 3;
      end
      if (prev != 0) m_halt = 1;
    end
  end

  always @(posedge clk) if (rst && t_valid && t_ready) popped.push_back({t_addr, t_data});

  always @(negedge clk) begin
    if (rst) begin
      chk("t_valid", t_valid, m_q.size() > 0);
      chk("t_head", {t_addr, t_data}, (m_q.size() > 0) ? m_q[0] : 64'd0);
      chk("fifo_level", fifo_level, m_q.size());
      chk("overflow", overflow, m_ovf);
      chk("drop_count", drop_count, m_dc);
      chk("store_count", store_count, m_sc);
      chk("status", status, m_status);
      chk("halt_req", halt_req, m_halt);
    end
  end

  task automatic step(input bit mw, input int a, input int d, input bit r);
    mem_write  = mw;
    alu_result = a;
    write_data = d;
    t_ready    = r;
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    mem_write = 0; alu_result = 0; write_data = 0; t_ready = 0;
    rst = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    popped.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, t_valid, 1'b0);
    chk({tag, "_head"}, {t_addr, t_data}, 64'd0);
    chk({tag, "_level"}, fifo_level, 0);
    chk({tag, "_ovf"}, overflow, 1'b0);
    chk({tag, "_cnts"}, {drop_count, store_count}, 0);
    chk({tag, "_status"}, status, 2'b00);
    chk({tag, "_halt"}, halt_req, 1'b0);
  endtask

  initial begin
    rst = 1'b0; mem_write = 0; alu_result = 0; write_data = 0; t_ready = 0;
    #1;
    chk_reset_vals("por");
    do_reset();

    // PASS run with continuous draining.
    step(1, 96, 7, 1);
    step(1, 96, 8, 1);
    step(1, 100, 25, 1);
    chk("s1_status", status, 2'b01);
    chk("s1_halt_early", halt_req, 1'b0);
    step(0, 0, 0, 1);
    chk("s1_halt", halt_req, 1'b1);
    chk("s1_store_count", store_count, 3);
    chk("s1_npop", popped.size(), 3);
    if (popped.size() == 3) begin
      chk("s1_pop0", popped[0], {32'd96, 32'd7});
      chk("s1_pop1", popped[1], {32'd96, 32'd8});
      chk("s1_pop2", popped[2], {32'd100, 32'd25});
    end

    // FAIL run; later stores ignored.
    do_reset();
    step(1, 100, 24, 0);
    chk("s2_status", status, 2'b10);
    chk("s2_halt_early", halt_req, 1'b0);
    step(1, 100, 25, 0);
    chk("s2_halt", halt_req, 1'b1);
    step(1, 100, 25, 0);
    chk("s2_status_hold", status, 2'b10);
    chk("s2_store_count", store_count, 1);

    // Overflow: 10 stores into an 8-deep FIFO, then drain.
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 96, i, 0);
    chk("s3_level", fifo_level, 8);
    chk("s3_ovf", overflow, 1'b1);
    chk("s3_drop", drop_count, 2);
    chk("s3_store_count", store_count, 10);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1);
    chk("s3_valid", t_valid, 1'b0);
    chk("s3_npop", popped.size(), 8);
    for (int i = 0; i < 8 && i < popped.size(); i++) chk("s3_pop", popped[i], {32'd96, 32'(i)});

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 96, i, 0);
    step(1, 96, 100, 1);
    chk("s4_level", fifo_level, 8);
    chk("s4_drop", {overflow, drop_count}, 0);
    chk("s4_head", t_data, 32'd1);

    // Counter saturation: 25 stores, 17 drops, both counters pinned at 15.
    do_reset();
    for (int i = 0; i < 25; i++) step(1, 96, i, 0);
    chk("s5_store_sat", store_count, 15);
    chk("s5_drop_sat", drop_count, 15);

    // TIMEOUT after TO cycles with no stores.
    do_reset();
    for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 0);
    chk("s6_run", status, 2'b00);
    step(0, 0, 0, 0);
    chk("s6_timeout", status, 2'b11);
    step(0, 0, 0, 0);
    chk("s6_halt", halt_req, 1'b1);

    // Signature store on the timeout cycle wins.
    do_reset();
    for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 0);
    step(1, 100, 25, 0);
    chk("s7_pass_wins", status, 2'b01);

    // Non-signature store on the timeout cycle: traced and counted, TIMEOUT.
    do_reset();
    for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 0);
    step(1, 96, 3, 0);
    chk("s7b_timeout", status, 2'b11);
    chk("s7b_level", fifo_level, 1);

    // Async reset mid-drain with 5 entries queued after PASS.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 96, i, 0);
    step(1, 100, 25, 0);
    step(0, 0, 0, 0);
    chk("s8_pre_level", fifo_level, 5);
    chk("s8_pre_status", status, 2'b01);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk_reset_vals("s8_async");
    #2 rst = 1'b1;
    popped.delete();
    @(negedge clk);
    #2;
    step(1, 100, 25, 0);
    chk("s8_pass_again", status, 2'b01);
    chk("s8_level", fifo_level, 1);
    step(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
